// File: rtl/traffic_led_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_led_monitor
// Brief    : Passive checker of the six traffic lamp lines (encoding, conflict,
//            sequence, dwell). Optional macro TRAFFIC_MON_STATS_EN adds cycle_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_led_monitor #(
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_CYC = 3,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r1,
    input  logic        g1,
    input  logic        y1,
    input  logic        r2,
    input  logic        g2,
    input  logic        y2,
    input  logic        clr,
    output logic [1:0]  phase1,
    output logic [1:0]  phase2,
    output logic        err_code,
    output logic        err_conflict,
    output logic        err_seq,
    output logic        err_time,
    output logic        err_pulse
`ifdef TRAFFIC_MON_STATS_EN
    ,
    output logic [15:0] cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_INV    = 2'd3
    } phase_e;

    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_sat       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_green_min = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] c_green_max = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] c_yellow    = CNT_W'(YELLOW_CYC);

    function automatic phase_e decode(input logic [2:0] lamps);
        case (lamps)
            3'b100:  return PH_RED;
            3'b010:  return PH_GREEN;
            3'b001:  return PH_YELLOW;
            default: return PH_INV;
        endcase
    endfunction

    function automatic phase_e succ(input phase_e p);
        case (p)
            PH_RED:    return PH_GREEN;
            PH_GREEN:  return PH_YELLOW;
            PH_YELLOW: return PH_RED;
            default:   return PH_INV;
        endcase
    endfunction

    // Index 0 is direction 1, index 1 is direction 2.
    logic [2:0]       lamp_q  [2];
    logic             smp_vld_q;
    phase_e           cur     [2];
    phase_e           last_q  [2];
    phase_e           last_d  [2];
    phase_e           ph_q    [2];
    phase_e           ph_d    [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       first_q, first_d;
    logic [3:0]       flag_q, flag_d;
    logic             pulse_q, pulse_d;
    logic             ev_code, ev_conf, ev_seq, ev_time, ev_any;

    assign cur[0] = decode(lamp_q[0]);
    assign cur[1] = decode(lamp_q[1]);

    always_comb begin
        ev_code = 1'b0;
        ev_conf = 1'b0;
        ev_seq  = 1'b0;
        ev_time = 1'b0;
        armed_d = armed_q;
        first_d = first_q;
        for (int i = 0; i < 2; i++) begin
            last_d[i] = last_q[i];
            cnt_d[i]  = cnt_q[i];
            ph_d[i]   = ph_q[i];
        end
        if (smp_vld_q) begin
            for (int i = 0; i < 2; i++) begin
                ph_d[i] = cur[i];
                if (cur[i] == PH_INV) begin
                    ev_code = 1'b1;
                end else if (!armed_q[i]) begin
                    armed_d[i] = 1'b1;
                    first_d[i] = 1'b1;
                    last_d[i]  = cur[i];
                    cnt_d[i]   = c_one;
                end else if (cur[i] == last_q[i]) begin
                    if (cnt_q[i] != c_sat) begin
                        cnt_d[i] = cnt_q[i] + c_one;
                    end
                    // Overrun fires only on the step past the limit, so once per phase.
                    if (!first_q[i] &&
                        ((cur[i] == PH_GREEN  && cnt_q[i] == c_green_max) ||
                         (cur[i] == PH_YELLOW && cnt_q[i] == c_yellow))) begin
                        ev_time = 1'b1;
                    end
                end else begin
                    if (cur[i] != succ(last_q[i])) begin
                        ev_seq = 1'b1;
                    end
                    if (!first_q[i] &&
                        ((last_q[i] == PH_GREEN  && cnt_q[i] <  c_green_min) ||
                         (last_q[i] == PH_YELLOW && cnt_q[i] != c_yellow))) begin
                        ev_time = 1'b1;
                    end
                    last_d[i]  = cur[i];
                    cnt_d[i]   = c_one;
                    first_d[i] = 1'b0;
                end
            end
            ev_conf = (cur[0] == PH_GREEN || cur[0] == PH_YELLOW) &&
                      (cur[1] == PH_GREEN || cur[1] == PH_YELLOW);
        end
        ev_any  = ev_code | ev_conf | ev_seq | ev_time;
        flag_d  = {ev_code, ev_conf, ev_seq, ev_time} | (flag_q & {4{~clr}});
        pulse_d = ev_any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                lamp_q[i] <= 3'b000;
                last_q[i] <= PH_RED;
                ph_q[i]   <= PH_INV;
                cnt_q[i]  <= '0;
            end
            smp_vld_q <= 1'b0;
            armed_q   <= 2'b00;
            first_q   <= 2'b00;
            flag_q    <= 4'b0000;
            pulse_q   <= 1'b0;
        end else begin
            lamp_q[0] <= {r1, g1, y1};
            lamp_q[1] <= {r2, g2, y2};
            for (int i = 0; i < 2; i++) begin
                last_q[i] <= last_d[i];
                ph_q[i]   <= ph_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            smp_vld_q <= 1'b1;
            armed_q   <= armed_d;
            first_q   <= first_d;
            flag_q    <= flag_d;
            pulse_q   <= pulse_d;
        end
    end

    assign phase1       = ph_q[0];
    assign phase2       = ph_q[1];
    assign err_code     = flag_q[3];
    assign err_conflict = flag_q[2];
    assign err_seq      = flag_q[1];
    assign err_time     = flag_q[0];
    assign err_pulse    = pulse_q;

`ifdef TRAFFIC_MON_STATS_EN
    logic        cyc_act_q, cyc_act_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;

    // A cycle opens on RED->GREEN of direction 1; any error anywhere voids it.
    always_comb begin
        cyc_act_d = cyc_act_q;
        cyc_cnt_d = cyc_cnt_q;
        if (smp_vld_q && armed_q[0] && cur[0] != PH_INV && cur[0] != last_q[0]) begin
            if (last_q[0] == PH_RED && cur[0] == PH_GREEN) begin
                cyc_act_d = 1'b1;
            end else if (last_q[0] == PH_YELLOW && cur[0] == PH_RED) begin
                if (cyc_act_q && !ev_any) begin
                    cyc_cnt_d = cyc_cnt_q + 16'd1;
                end
                cyc_act_d = 1'b0;
            end
        end
        if (ev_any) begin
            cyc_act_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_act_q <= 1'b0;
            cyc_cnt_q <= 16'd0;
        end else begin
            cyc_act_q <= cyc_act_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign cycle_cnt = cyc_cnt_q;
`endif

endmodule
`default_nettype wire
